// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, line/frame total derivation and
// colour-split helpers for the frame fetch and text-overlay blocks.
package vga_pkg;

    // 640x480@60 default timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // framebuffer word is packed {R,G,B}, equal channel widths
    localparam int DEF_COLOR_W  = 12;
    localparam int CH_W         = DEF_COLOR_W / 3;

    // IDLE: counters parked at (0,0) waiting for the first pixel tick
    typedef enum logic {
        TM_IDLE = 1'b0,
        TM_RUN  = 1'b1
    } tm_state_e;

    function automatic int line_total(
        input int act,
        input int fp,
        input int sync,
        input int bp
    );
        return act + fp + sync + bp;
    endfunction

    function automatic int ch_width(input int color_w);
        return color_w / 3;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: horizontal/vertical pixel counters with wrap strobes,
// frame_start pulse and raw (active-high) sync and active-video flags.
// Ports: clk, reset (async, active-high), pix_tick, enable in;
//        h_cnt, v_cnt, line_wrap, frame_wrap (comb strobes),
//        frame_start (registered), hsync_raw, vsync_raw, active out.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW       = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_tick,
    input  logic          enable,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_wrap,
    output logic          frame_wrap,
    output logic          frame_start,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          active
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    tm_state_e     state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          fs_q, fs_d;
    logic          run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TM_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fs_q    <= fs_d;
        end
    end

    // The first tick after a restart only "enters" (0,0); later ticks advance.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        fs_d       = 1'b0;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (!enable) begin
            state_d = TM_IDLE;
            h_d     = '0;
            v_d     = '0;
        end else if (pix_tick) begin
            unique case (state_q)
                TM_IDLE: begin
                    state_d = TM_RUN;
                    fs_d    = 1'b1;
                end
                TM_RUN: begin
                    if (h_q == H_LAST) begin
                        h_d       = '0;
                        line_wrap = 1'b1;
                        if (v_q == V_LAST) begin
                            v_d        = '0;
                            frame_wrap = 1'b1;
                            fs_d       = 1'b1;
                        end else begin
                            v_d = v_q + VW'(1);
                        end
                    end else begin
                        h_d = h_q + HW'(1);
                    end
                end
            endcase
        end
    end

    assign run         = (state_q == TM_RUN);
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign frame_start = fs_q;
    assign hsync_raw   = run && (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync_raw   = run && (v_q >= VS_BEG) && (v_q < VS_END);
    assign active      = run && (h_q < H_ACT) && (v_q < V_ACT);

endmodule

// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch: VGA timing, framebuffer address generation with
// power-of-two downscaling, and a 2-tick pipeline to blanked RGB/sync pins.
// Ports: clk, reset (async, active-high), pix_tick, enable, mem_data in;
//        mem_addr, mem_rd, vga_r/g/b, hsync, vsync, frame_start out.
module vga_frame_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int SCALE_SHIFT = 0,
    parameter bit SYNC_POL    = 1'b0,
    parameter int ADDR_W      =
        $clog2((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_tick,
    input  logic                 enable,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [COLOR_W-1:0]   mem_data,
    output logic [COLOR_W/3-1:0] vga_r,
    output logic [COLOR_W/3-1:0] vga_g,
    output logic [COLOR_W/3-1:0] vga_b,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start
);

    localparam int HW   = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW   = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int C_W  = ch_width(COLOR_W);

    localparam logic [ADDR_W-1:0] FB_W     = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     ROW_MASK = VW'((1 << SCALE_SHIFT) - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_wrap, frame_wrap;
    logic          hs_raw, vs_raw, active;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_tick    (pix_tick),
        .enable      (enable),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .line_wrap   (line_wrap),
        .frame_wrap  (frame_wrap),
        .frame_start (frame_start),
        .hsync_raw   (hs_raw),
        .vsync_raw   (vs_raw),
        .active      (active)
    );

    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, addr0;
    logic               rd_q, rd_d;
    logic               act1_q, act1_d;
    logic               hs1_q, hs1_d;
    logic               vs1_q, vs1_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [VW-1:0]      v_nxt;
    logic               row_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base_q <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            act1_q     <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            rgb_q      <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
        end else begin
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            act1_q     <= act1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    // Row base steps one framebuffer line each time the next screen line
    // is active and starts a new block of 2^SCALE_SHIFT screen lines.
    always_comb begin
        v_nxt      = v_cnt + VW'(1);
        row_step   = (v_nxt < V_ACT) && ((v_nxt & ROW_MASK) == '0);
        row_base_d = row_base_q;
        if (!enable || frame_wrap) begin
            row_base_d = '0;
        end else if (line_wrap && row_step) begin
            row_base_d = row_base_q + FB_W;
        end
        addr0 = row_base_q + ADDR_W'(h_cnt >> SCALE_SHIFT);
    end

    // Stage 1: read request for the current counter position.
    always_comb begin
        addr_d = addr_q;
        rd_d   = 1'b0;
        act1_d = act1_q;
        hs1_d  = hs1_q;
        vs1_d  = vs1_q;
        if (!enable) begin
            addr_d = '0;
            act1_d = 1'b0;
            hs1_d  = 1'b0;
            vs1_d  = 1'b0;
        end else if (pix_tick) begin
            rd_d   = active;
            act1_d = active;
            hs1_d  = hs_raw;
            vs1_d  = vs_raw;
            if (active) begin
                addr_d = addr0;
            end
        end
    end

    // Stage 2: read data returns; sync and blank travel alongside it.
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (!enable) begin
            rgb_d   = '0;
            hsync_d = ~SYNC_POL;
            vsync_d = ~SYNC_POL;
        end else if (pix_tick) begin
            rgb_d   = act1_q ? mem_data : '0;
            hsync_d = hs1_q ? SYNC_POL : ~SYNC_POL;
            vsync_d = vs1_q ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign mem_addr = addr_q;
    assign mem_rd   = rd_q;
    assign vga_r    = rgb_q[COLOR_W-1 -: C_W];
    assign vga_g    = rgb_q[COLOR_W-C_W-1 -: C_W];
    assign vga_b    = rgb_q[C_W-1:0];
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// tb_vga_frame_fetch: drives a reduced-size timing (24x13 totals) into two
// instances, unscaled and 2x downscaled, and scores every pixel tick.
module tb_vga_frame_fetch;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int AW0 = 7;
    localparam int AW1 = 5;

    logic clk = 1'b0;
    logic reset, pix_tick, enable;

    logic [AW0-1:0] addr0;
    logic           rd0, hs0, vs0, fs0;
    logic [11:0]    data0;
    logic [3:0]     r0, g0, b0;

    logic [AW1-1:0] addr1;
    logic           rd1, hs1, vs1, fs1;
    logic [11:0]    data1;
    logic [3:0]     r1, g1, b1;

    always #5 clk = ~clk;

    vga_frame_fetch #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_W(12), .SCALE_SHIFT(0), .SYNC_POL(1'b0)
    ) u_s0 (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .enable(enable),
        .mem_addr(addr0), .mem_rd(rd0), .mem_data(data0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .hsync(hs0), .vsync(vs0), .frame_start(fs0)
    );

    vga_frame_fetch #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_W(12), .SCALE_SHIFT(1), .SYNC_POL(1'b0)
    ) u_s1 (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .enable(enable),
        .mem_addr(addr1), .mem_rd(rd1), .mem_data(data1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    // RAM models: data = address; between reads they return all-ones
    always @(posedge clk) begin
        if (rd0) data0 <= 12'(addr0);
        else if (pix_tick) data0 <= 12'hFFF;
        if (rd1) data1 <= 12'(addr1);
        else if (pix_tick) data1 <= 12'hFFF;
    end

    int rd_cnt = 0;
    int fs_cnt = 0;
    always @(posedge clk) begin
        if (rd0) rd_cnt <= rd_cnt + 1;
        if (fs0) fs_cnt <= fs_cnt + 1;
    end

    typedef struct packed {
        logic           fs;
        logic           act;
        logic           hs;
        logic           vs;
        logic [AW0-1:0] a0;
        logic [AW1-1:0] a1;
    } exp_t;

    exp_t           sb[$];
    int             n_run;
    logic [AW0-1:0] last_a0;
    logic [AW1-1:0] last_a1;
    int             n_chk = 0;
    int             n_fail = 0;
    int             rd_base, fs_base;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected state for the n-th counter position after a restart
    function automatic exp_t model(input int n);
        exp_t e;
        int p, x, y;
        p = n % (HT * VT);
        x = p % HT;
        y = p / HT;
        e.fs  = (p == 0);
        e.act = (x < HA) && (y < VA);
        e.hs  = (x >= HA + HFP) && (x < HA + HFP + HS);
        e.vs  = (y >= VA + VFP) && (y < VA + VFP + VS);
        e.a0  = AW0'(y * HA + x);
        e.a1  = AW1'((y / 2) * (HA / 2) + x / 2);
        return e;
    endfunction

    task automatic clear_model();
        sb.delete();
        n_run   = 0;
        last_a0 = '0;
        last_a1 = '0;
    endtask

    task automatic check_pins(input logic fs_exp);
        exp_t s1, s2;
        logic [11:0] d0, d1;
        s1 = '0;
        s2 = '0;
        if (sb.size() >= 2) s1 = sb[sb.size() - 2];
        if (sb.size() >= 3) s2 = sb.pop_front();
        if (s1.act) begin
            last_a0 = s1.a0;
            last_a1 = s1.a1;
        end
        d0 = s2.act ? 12'(s2.a0) : 12'h000;
        d1 = s2.act ? 12'(s2.a1) : 12'h000;
        chk("fs0", 32'(fs0), 32'(fs_exp));
        chk("fs1", 32'(fs1), 32'(fs_exp));
        chk("rd0", 32'(rd0), 32'(s1.act));
        chk("rd1", 32'(rd1), 32'(s1.act));
        chk("addr0", 32'(addr0), 32'(last_a0));
        chk("addr1", 32'(addr1), 32'(last_a1));
        chk("rgb0", 32'({r0, g0, b0}), 32'(d0));
        chk("rgb1", 32'({r1, g1, b1}), 32'(d1));
        chk("hsync0", 32'(hs0), 32'(!s2.hs));
        chk("hsync1", 32'(hs1), 32'(!s2.hs));
        chk("vsync0", 32'(vs0), 32'(!s2.vs));
        chk("vsync1", 32'(vs1), 32'(!s2.vs));
    endtask

    // one pixel period of 4 clocks
    task automatic do_tick();
        logic fs_exp;
        @(negedge clk);
        pix_tick = 1'b1;
        fs_exp   = 1'b0;
        sb.push_back(model(n_run));
        fs_exp = sb[sb.size() - 1].fs;
        n_run++;
        @(negedge clk);
        pix_tick = 1'b0;
        check_pins(fs_exp);
        @(negedge clk);
        chk("rd0_width", 32'(rd0), 32'd0);
        chk("rd1_width", 32'(rd1), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        pix_tick = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check_pins(1'b0);

        reset   = 1'b0;
        enable  = 1'b1;
        rd_base = rd_cnt;
        fs_base = fs_cnt;
        repeat (HT * VT + 1) do_tick();
        chk("rd_per_frame", 32'(rd_cnt - rd_base), 32'(HA * VA));
        repeat (HT * VT - 1) do_tick();
        chk("fs_per_2frames", 32'(fs_cnt - fs_base), 32'd2);

        // reach (10,5), then drop enable together with a pixel tick
        repeat (5 * HT + 11) do_tick();
        @(negedge clk);
        enable   = 1'b0;
        pix_tick = 1'b1;
        clear_model();
        @(negedge clk);
        pix_tick = 1'b0;
        check_pins(1'b0);
        repeat (3) @(negedge clk);
        pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
        check_pins(1'b0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (6 * HT + 13) do_tick();

        // async reset just after a tick edge at (12,6)
        @(negedge clk);
        pix_tick = 1'b1;
        @(posedge clk);
        #2;
        pix_tick = 1'b0;
        reset    = 1'b1;
        #1;
        clear_model();
        check_pins(1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * HT) do_tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
